// File: rtl/mem_cal_seq.sv
// Power-up sequencer for the memory interfaces and the kernel clock domain.
// Order: POR settle, PLL lock, memory soft reset, calibration with retries, kernel reset, ready.
module mem_cal_seq #(
  parameter int NUM_MEM     = 6,
  parameter int POR_CYCLES  = 1024,
  parameter int RST_HOLD    = 64,
  parameter int CAL_TIMEOUT = 1048576,
  parameter int MAX_RETRY   = 3,
  parameter int KRST_HOLD   = 16,
  parameter int HB_BIT      = 24
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               npor,
  input  logic               kernel_pll_locked,
  input  logic [NUM_MEM-1:0] mem_pll_locked,
  input  logic [NUM_MEM-1:0] mem_cal_success,
  input  logic [NUM_MEM-1:0] mem_cal_fail,
  output logic [NUM_MEM-1:0] mem_soft_reset_n,
  output logic               kernel_reset_n,
  output logic               sys_ready,
  output logic               error,
  output logic [1:0]         retry_cnt,
  output logic [7:0]         leds
);

  localparam logic [2:0] ST_POR   = 3'd0;
  localparam logic [2:0] ST_PLL   = 3'd1;
  localparam logic [2:0] ST_MRST  = 3'd2;
  localparam logic [2:0] ST_CAL   = 3'd3;
  localparam logic [2:0] ST_KRST  = 3'd4;
  localparam logic [2:0] ST_READY = 3'd5;
  localparam logic [2:0] ST_FAIL  = 3'd6;

  localparam int SW    = 2 + 3 * NUM_MEM;
  localparam int MAX_A = (POR_CYCLES > RST_HOLD) ? POR_CYCLES : RST_HOLD;
  localparam int MAX_B = (CAL_TIMEOUT > KRST_HOLD) ? CAL_TIMEOUT : KRST_HOLD;
  localparam int CW    = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);

  logic [SW-1:0]      sync1_q, sync2_q;
  logic               npor_s, kpll_s, all_locked_s, cal_fail_s;
  logic [NUM_MEM-1:0] mem_pll_s, cal_ok_s, cal_bad_s;
  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         retry_q, retry_d;
  logic [HB_BIT:0]    hb_q;
  logic               mem_on_d, ready_d, error_d;

  assign npor_s    = sync2_q[SW-1];
  assign kpll_s    = sync2_q[SW-2];
  assign mem_pll_s = sync2_q[3*NUM_MEM-1 -: NUM_MEM];
  assign cal_ok_s  = sync2_q[2*NUM_MEM-1 -: NUM_MEM];
  assign cal_bad_s = sync2_q[NUM_MEM-1:0];

  assign all_locked_s = kpll_s & (&mem_pll_s);
  // A timeout or a fail flag wins over a coincident success.
  assign cal_fail_s   = (|cal_bad_s) | (cnt_q == CW'(CAL_TIMEOUT - 1));

  // Next-state, shared phase counter and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    retry_d = retry_q;
    if (!npor_s) begin
      state_d = ST_POR;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        ST_POR: begin
          if (cnt_q == CW'(POR_CYCLES - 1)) state_d = ST_PLL;
          else                              cnt_d   = cnt_q + CW'(1);
        end
        ST_PLL: begin
          if (all_locked_s) state_d = ST_MRST;
          else              state_d = ST_PLL;
        end
        ST_MRST: begin
          if (cnt_q == CW'(RST_HOLD - 1)) state_d = ST_CAL;
          else                            cnt_d   = cnt_q + CW'(1);
        end
        ST_CAL: begin
          if (cal_fail_s) begin
            if (retry_q < 2'(MAX_RETRY)) begin
              retry_d = retry_q + 2'd1;
              state_d = ST_MRST;
            end else begin
              state_d = ST_FAIL;
            end
          end else if (&cal_ok_s) begin
            state_d = ST_KRST;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_KRST: begin
          if (cnt_q == CW'(KRST_HOLD - 1)) state_d = ST_READY;
          else                             cnt_d   = cnt_q + CW'(1);
        end
        ST_READY: begin
          if (!all_locked_s) state_d = ST_PLL;
          else               state_d = ST_READY;
        end
        ST_FAIL:  state_d = ST_FAIL;
        default:  state_d = ST_POR;
      endcase
    end
  end

  assign mem_on_d = (state_d == ST_CAL) | (state_d == ST_KRST) | (state_d == ST_READY);
  assign ready_d  = (state_d == ST_READY);
  assign error_d  = (state_d == ST_FAIL);

  // Input synchronizers, FSM state and outputs all register on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      state_q          <= ST_POR;
      cnt_q            <= '0;
      retry_q          <= 2'd0;
      hb_q             <= '0;
      mem_soft_reset_n <= '0;
      kernel_reset_n   <= 1'b0;
      sys_ready        <= 1'b0;
      error            <= 1'b0;
      retry_cnt        <= 2'd0;
      leds             <= 8'h00;
    end else begin
      sync1_q          <= {npor, kernel_pll_locked, mem_pll_locked, mem_cal_success, mem_cal_fail};
      sync2_q          <= sync1_q;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      retry_q          <= retry_d;
      hb_q             <= hb_q + {{HB_BIT{1'b0}}, 1'b1};
      mem_soft_reset_n <= mem_on_d ? '1 : '0;
      kernel_reset_n   <= ready_d;
      sys_ready        <= ready_d;
      error            <= error_d;
      retry_cnt        <= retry_d;
      leds             <= {hb_q[HB_BIT], error_d, ready_d, retry_d, state_d};
    end
  end

endmodule

// File: doc/mem_cal_seq.md
MEM_CAL_SEQ -- requirements
Module: mem_cal_seq

Interface
REQ-001 SHALL have parameter NUM_MEM, default 6: number of memory interfaces (DDR3/QDRII) sequenced.
REQ-002 SHALL have parameter POR_CYCLES, default 1024: power-on settle cycles after npor is seen high.
REQ-003 SHALL have parameter RST_HOLD, default 64: memory soft-reset assertion width in cycles.
REQ-004 SHALL have parameter CAL_TIMEOUT, default 1048576: calibration timeout in cycles.
REQ-005 SHALL have parameter MAX_RETRY, default 3 (max 3): calibration retries before fail.
REQ-006 SHALL have parameter KRST_HOLD, default 16: kernel reset assertion width in cycles.
REQ-007 SHALL have parameter HB_BIT, default 24: heartbeat counter bit driven to leds[7].
REQ-008 Ports, one per line: name, direction, width, meaning:
- clk  in  1  single clock (50 MHz config clock); all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- npor  in  1  PCIe power-on-reset-done, async, active-high.
- kernel_pll_locked  in  1  kernel PLL lock, async.
- mem_pll_locked  in  NUM_MEM  per-interface PLL lock, async.
- mem_cal_success  in  NUM_MEM  per-interface calibration pass, async.
- mem_cal_fail  in  NUM_MEM  per-interface calibration fail, async.
- mem_soft_reset_n  out  NUM_MEM  active-low soft reset to memory controllers.
- kernel_reset_n  out  1  active-low kernel reset.
- sys_ready  out  1  system up.
- error  out  1  calibration failed permanently.
- retry_cnt  out  2  retries consumed.
- leds  out  8  status, active-high.

Function
REQ-009 All async inputs SHALL pass a 2-flop synchronizer; decisions use synchronized values (2-cycle input latency).
REQ-010 FSM states SHALL be POR(0), PLL(1), MRST(2), CAL(3), KRST(4), READY(5), FAIL(6).
REQ-011 POR: counter increments while npor_s=1, clears while 0; on reaching POR_CYCLES-1 SHALL go to PLL.
REQ-012 PLL: when kernel_pll_locked_s and all mem_pll_locked_s are 1 SHALL go to MRST; no timeout.
REQ-013 MRST: mem_soft_reset_n all 0 for exactly RST_HOLD cycles, then SHALL go to CAL.
REQ-014 CAL: timeout counter starts at 0 on entry; all mem_cal_success_s=1 SHALL go to KRST.
REQ-015 CAL: any mem_cal_fail_s=1 or counter reaching CAL_TIMEOUT-1 is a failure; success and failure in the same cycle SHALL count as failure.
REQ-016 On failure: retry_cnt<MAX_RETRY SHALL increment retry_cnt and go to MRST; else go to FAIL.
REQ-017 KRST: kernel_reset_n=0 for exactly KRST_HOLD cycles, then SHALL go to READY.
REQ-018 READY: sys_ready=1, kernel_reset_n=1, mem_soft_reset_n all 1; any PLL lock drop SHALL go to PLL (kernel and memory resets reasserted next cycle).
REQ-019 FAIL: error=1, mem_soft_reset_n all 0, kernel_reset_n=0; held until npor_s falls or resetn.
REQ-020 npor_s=0 in any state other than POR SHALL force POR next cycle and clear retry_cnt; highest priority.
REQ-021 mem_soft_reset_n SHALL be 0 in POR, PLL, MRST, FAIL and 1 in CAL, KRST, READY; kernel_reset_n 1 only in READY.
REQ-022 leds[2:0]=state, leds[4:3]=retry_cnt, leds[5]=sys_ready, leds[6]=error, leds[7]=free-running counter bit HB_BIT.
REQ-023 All outputs SHALL be registered; output change follows state change in the same cycle as the state register.

Reset
REQ-024 resetn=0 SHALL asynchronously set state POR, all counters and synchronizers 0, mem_soft_reset_n=0, kernel_reset_n=0, sys_ready=0, error=0, retry_cnt=0, leds=8'h00.
REQ-025 resetn deassertion SHALL take effect on the next rising clk edge; reset mid-sequence restarts at POR.

Verification (POR_CYCLES=8, RST_HOLD=4, CAL_TIMEOUT=32, MAX_RETRY=2, KRST_HOLD=2, NUM_MEM=2)
REQ-026 Clean boot: npor=1, PLLs locked, cal_success=2'b11 -> sys_ready=1 with leds[2:0]=5, retry_cnt=0; mem_soft_reset_n low exactly 4 cycles in MRST.
REQ-027 One fail: mem_cal_fail[1] pulse on first CAL pass -> retry_cnt=1, MRST re-entered, then READY with leds[4:3]=1.
REQ-028 Timeout exhaustion: cal_success held 2'b01 -> 3 CAL timeouts of 32 cycles, error=1, leds[6]=1, state 6, all resets low.
REQ-029 Lock loss: in READY drop mem_pll_locked[0] -> within 3 cycles sys_ready=0, kernel_reset_n=0, state 1; relock -> MRST, CAL, READY.
REQ-030 npor drop during CAL with retry_cnt=1 -> state POR, retry_cnt=0; simultaneous cal_fail ignored; resetn pulse mid-KRST -> all outputs reset values immediately.
